alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Two-requester arbiter and sequencer for one shared ALU instance.
- Each requester issues an op plus two operands over a valid/ready handshake.
- The block picks one request per cycle by round-robin, drives the ALU, and registers the result into a single response slot with backpressure.
- Sits between the issue logic (e.g. main pipe and a branch/address unit) and the ALU, so only one ALU is built.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OP_NUM, 12, width of the one-hot op vector. Bit order: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (bit 0 to bit 11).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  OP_NUM  one-hot op, requester 0.
- req0_src1  in  DATA_WIDTH  operand 1, requester 0.
- req0_src2  in  DATA_WIDTH  operand 2, requester 0.
- req1_valid, req1_ready, req1_op, req1_src1, req1_src2: same as requester 0, for requester 1.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index that owns the result.
- rsp_result  out  DATA_WIDTH  registered ALU result.
- rsp_err  out  1  illegal op flag (see Optional Feature).

Behaviour:
- Reset (async, reset=1):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready=req1_ready=0 while reset is held.
- Slot states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready). This is a same-cycle drain-and-refill, with no bubble.
- Grant (combinational, only when can_accept):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the index != last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N. It never depends on the other requester's ready. At most one ready is high per cycle.
- ALU input mux: the granted requester's op/src1/src2. When there is no grant, drive all-zero op (ALU result 0).
- On a handshake (reqN_valid & reqN_ready):
  - Next edge: rsp_valid=1, rsp_id=N, rsp_result=ALU output, last_grant=N.
  - Latency is 1 cycle from accept to rsp_valid.
- Drain without new accept (FULL & rsp_ready & no grant): next edge rsp_valid=0. rsp_result and rsp_id hold their values.
- FULL & !rsp_ready:
  - Slot holds and outputs stay stable.
  - Both readies are 0.
  - last_grant is unchanged, so the pending loser keeps priority.
- Requesters must hold valid and payload stable until ready. The arbiter never drops a valid request.
- Fairness: under continuous dual requests with rsp_ready=1, grants alternate 0,1,0,1,… and throughput is 1 op/cycle.
- ALU arithmetic:
  - Adder is DATA_WIDTH wrap-around.
  - slt is signed; sltu is unsigned.
  - Shift amount is src1[4:0], shifting src2.
  - lui = {src2[15:0], 16'b0}.
- Reset mid-operation: any held result is discarded and rsp_valid drops asynchronously. After release, requester 0 wins the first contention.

Optional Feature:
- Macro: ALU_SHARE_ARB_OPCHECK_EN.
- Defined:
  - The granted op is checked for exactly one bit set.
  - Zero or multiple bits set: the request is still accepted, rsp_result=0, rsp_err=1 for that response.
  - Legal op: rsp_err=0.
- Undefined:
  - No check; the op goes straight to the ALU, so multiple bits OR their results.
  - rsp_err is tied to 0.

Test Plan:
- Reset release, only req0: op=add, src1=5, src2=7, rsp_ready=1 → req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
- Both valid continuously for 4 cycles, rsp_ready=1 → req0 sub 3−5 gives 0xFFFFFFFE with id0; req1 sltu 1<2 gives 1 with id1. Grants are 0,1,0,1.
- Backpressure: slot FULL, rsp_ready=0 for 3 cycles with req1 sll (src1=4, src2=1) pending → readies stay 0 and rsp_result is stable. When rsp_ready rises, req1 is accepted the same cycle and the next rsp_result=0x10.
- Signed compare: slt src1=0x80000000, src2=1 gives 1; sltu with the same operands gives 0. sra src1=4, src2=0x80000000 gives 0xF8000000.
- Reset asserted while FULL → rsp_valid=0 immediately (no clock edge). After release, with both valid, req0 is granted first.
- OPCHECK_EN defined, op=0x003 → rsp_valid=1, rsp_err=1, rsp_result=0. Undefined → rsp_err=0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Handshake bundle between two issue requesters, the shared-ALU arbiter and
// the single response consumer. The master side drives requests and
// rsp_ready. The slave side is the arbiter.
interface alu_share_arb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_NUM     = 12
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [OP_NUM-1:0]     req0_op;
    logic [DATA_WIDTH-1:0] req0_src1;
    logic [DATA_WIDTH-1:0] req0_src2;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [OP_NUM-1:0]     req1_op;
    logic [DATA_WIDTH-1:0] req1_src1;
    logic [DATA_WIDTH-1:0] req1_src2;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_err;

    modport master (
        output req0_valid, req0_op, req0_src1, req0_src2,
        output req1_valid, req1_op, req1_src1, req1_src2,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_src1, req0_src2,
        input  req1_valid, req1_op, req1_src1, req1_src2,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter and sequencer in front of one shared ALU. It accepts
// one request per cycle into a single registered response slot with
// backpressure. The slot drains and refills in the same cycle.
// Optional macro ALU_SHARE_ARB_OPCHECK_EN: a non-one-hot op gives result 0
// with rsp_err=1. Without the macro, the op bits OR their results and
// rsp_err stays 0.
module alu_share_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_NUM     = 12
) (
    input  logic          clk,
    input  logic          reset,
    alu_share_arb_if.slave bus
);
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e                 state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  can_accept;
    logic                  grant_vld;
    logic                  grant_idx;

    logic [OP_NUM-1:0]     alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [SHAMT_W-1:0]    shamt;
    logic                  op_err;

    // Slot acceptance and round-robin grant; nothing is granted while reset is held
    always_comb begin
        can_accept = 1'b0;
        grant_vld  = 1'b0;
        grant_idx  = 1'b0;
        if (!reset) begin
            can_accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
        end
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_vld = 1'b1;
                grant_idx = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (bus.req1_valid) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_vld && !grant_idx;
    assign bus.req1_ready = grant_vld &&  grant_idx;

    // ALU operand mux: granted requester, or an all-zero op when idle
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (grant_vld) begin
            if (grant_idx) begin
                alu_op = bus.req1_op;
                alu_a  = bus.req1_src1;
                alu_b  = bus.req1_src2;
            end else begin
                alu_op = bus.req0_op;
                alu_a  = bus.req0_src1;
                alu_b  = bus.req0_src2;
            end
        end
    end

    // Shared ALU: every selected op bit contributes its result to an OR
    always_comb begin
        shamt   = alu_a[SHAMT_W-1:0];
        alu_res = '0;
        if (alu_op[0])  alu_res = alu_res | (alu_a + alu_b);
        if (alu_op[1])  alu_res = alu_res | (alu_a - alu_b);
        if (alu_op[2])  alu_res = alu_res | DATA_WIDTH'($signed(alu_a) < $signed(alu_b));
        if (alu_op[3])  alu_res = alu_res | DATA_WIDTH'(alu_a < alu_b);
        if (alu_op[4])  alu_res = alu_res | (alu_a & alu_b);
        if (alu_op[5])  alu_res = alu_res | ~(alu_a | alu_b);
        if (alu_op[6])  alu_res = alu_res | (alu_a | alu_b);
        if (alu_op[7])  alu_res = alu_res | (alu_a ^ alu_b);
        if (alu_op[8])  alu_res = alu_res | (alu_b << shamt);
        if (alu_op[9])  alu_res = alu_res | (alu_b >> shamt);
        if (alu_op[10]) alu_res = alu_res | DATA_WIDTH'($signed(alu_b) >>> shamt);
        if (alu_op[11]) alu_res = alu_res | DATA_WIDTH'({alu_b[15:0], 16'h0000});
    end

`ifdef ALU_SHARE_ARB_OPCHECK_EN
    // Flag any op that is not exactly one-hot
    always_comb begin
        op_err = !((alu_op != '0) && ((alu_op & (alu_op - OP_NUM'(1))) == '0));
    end
`else
    assign op_err = 1'b0;
`endif

    // Slot next-state: load on grant, drain when consumed, hold under backpressure
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (grant_vld) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!grant_vld && bus.rsp_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (grant_vld) begin
            last_grant_d = grant_idx;
            rsp_id_d     = grant_idx;
            rsp_result_d = op_err ? '0 : alu_res;
            rsp_err_d    = op_err;
        end
    end

    // Slot and arbitration state; reset leaves requester 0 with priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SLOT_EMPTY;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.rsp_valid  = (state_q == SLOT_FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
